// File: rtl/sm_addsub_pipe.sv
// rtl/sm_addsub_pipe.sv - two-stage multi-lane sign-magnitude adder/subtractor with saturation and overflow count
module sm_addsub_pipe #(
    parameter int BITS    = 16,
    parameter int FIX_BIT = 7,
    parameter int LANES   = 2,
    parameter int SAT     = 1,
    parameter int CNT_W   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [LANES-1:0]       i_sub,
    input  logic [LANES*BITS-1:0]  i_input0,
    input  logic [LANES*BITS-1:0]  i_input1,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [LANES*BITS-1:0]  o_output,
    output logic [LANES-1:0]       o_ovf,
    output logic [CNT_W-1:0]       o_ovf_cnt,
    input  logic                   i_ovf_clr
);

    if (FIX_BIT >= BITS - 1) begin : g_fix_check
        $error("FIX_BIT must leave at least one integer magnitude bit");
    end

    // Sign-magnitude to BITS+1 two's complement; neg flips the sign (subtract), -0 maps to 0.
    function automatic logic [BITS:0] sm_to_tc(input logic [BITS-1:0] v, input logic neg);
        logic [BITS:0] mag;
        mag = {2'b00, v[BITS-2:0]};
        return (v[BITS-1] ^ neg) ? -mag : mag;
    endfunction

    // Returns {ovf, sign, magnitude}; a zero magnitude always carries a positive sign.
    function automatic logic [BITS:0] tc_to_sm(input logic [BITS:0] r);
        logic [BITS:0]   abs_v;
        logic            ovf;
        logic [BITS-2:0] mag;
        abs_v = r[BITS] ? -r : r;
        ovf   = |abs_v[BITS:BITS-1];
        if (ovf && (SAT != 0)) mag = '1;
        else                   mag = abs_v[BITS-2:0];
        return {ovf, r[BITS] & (|mag), mag};
    endfunction

    logic                  r_s1_valid;
    logic [BITS:0]         r_s1_sum [LANES];
    logic                  r_s2_valid;
    logic [LANES*BITS-1:0] r_s2_data;
    logic [LANES-1:0]      r_s2_ovf;
    logic [CNT_W-1:0]      r_ovf_cnt;

    logic                  w_s1_load;
    logic                  w_s2_load;
    logic                  w_out_fire;
    logic [BITS:0]         w_sum  [LANES];
    logic [BITS:0]         w_conv [LANES];
    logic [LANES*BITS-1:0] w_s2_data;
    logic [LANES-1:0]      w_s2_ovf;

    // S1 may refill in the same cycle S2 hands its word downstream, so bubbles collapse.
    assign w_s2_load  = !r_s2_valid || i_out_ready;
    assign w_s1_load  = !r_s1_valid || w_s2_load;
    assign w_out_fire = r_s2_valid && i_out_ready;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_sum[k] = sm_to_tc(i_input0[k*BITS +: BITS], 1'b0)
                     + sm_to_tc(i_input1[k*BITS +: BITS], i_sub[k]);
        end
    end

    always_comb begin
        w_s2_data = '0;
        w_s2_ovf  = '0;
        for (int k = 0; k < LANES; k++) begin
            w_conv[k]                 = tc_to_sm(r_s1_sum[k]);
            w_s2_data[k*BITS +: BITS] = w_conv[k][BITS-1:0];
            w_s2_ovf[k]               = w_conv[k][BITS];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_s1_sum[k] <= '0;
            end
        end else if (w_s1_load) begin
            r_s1_valid <= i_in_valid;
            for (int k = 0; k < LANES; k++) begin
                r_s1_sum[k] <= w_sum[k];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_ovf   <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= w_s2_data;
            r_s2_ovf   <= w_s2_ovf;
        end
    end

    // Clear takes priority over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf_cnt <= '0;
        end else if (i_ovf_clr) begin
            r_ovf_cnt <= '0;
        end else if (w_out_fire && (|r_s2_ovf) && !(&r_ovf_cnt)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign o_in_ready  = w_s1_load;
    assign o_out_valid = r_s2_valid;
    assign o_output    = r_s2_data;
    assign o_ovf       = r_s2_ovf;
    assign o_ovf_cnt   = r_ovf_cnt;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// tb/tb_sm_addsub_pipe.sv - directed bench for sm_addsub_pipe with saturating and wrapping instances
module tb_sm_addsub_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_in_valid;
    logic [1:0]  i_sub;
    logic [31:0] i_input0;
    logic [31:0] i_input1;
    logic        i_out_ready;
    logic        i_ovf_clr;

    logic        o_in_ready,  o_in_ready_w;
    logic        o_out_valid, o_out_valid_w;
    logic [31:0] o_output,    o_output_w;
    logic [1:0]  o_ovf,       o_ovf_w;
    logic [7:0]  o_ovf_cnt,   o_ovf_cnt_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    sm_addsub_pipe #(.BITS(16), .FIX_BIT(7), .LANES(2), .SAT(1), .CNT_W(8)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_sub(i_sub), .i_input0(i_input0), .i_input1(i_input1), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_output(o_output), .o_ovf(o_ovf), .o_ovf_cnt(o_ovf_cnt),
        .i_ovf_clr(i_ovf_clr)
    );

    sm_addsub_pipe #(.BITS(16), .FIX_BIT(7), .LANES(2), .SAT(0), .CNT_W(8)) u_dut_wrap (
        .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready_w),
        .i_sub(i_sub), .i_input0(i_input0), .i_input1(i_input1), .o_out_valid(o_out_valid_w),
        .i_out_ready(i_out_ready), .o_output(o_output_w), .o_ovf(o_ovf_w), .o_ovf_cnt(o_ovf_cnt_w),
        .i_ovf_clr(i_ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One beat in, then step to the cycle where its result should be valid.
    task automatic run1(input logic [1:0] sub, input logic [31:0] a, input logic [31:0] b);
        i_sub = sub; i_input0 = a; i_input1 = b; i_in_valid = 1'b1;
        tick();
        i_in_valid = 1'b0;
        chk("latency_not_early", 32'(o_out_valid), 32'd0);
        tick();
    endtask

    function automatic logic [31:0] exp4(input int k);
        return {16'h800F - 16'(k), 16'h0011 + 16'(k)};
    endfunction

    initial begin
        int sent;
        int recv;
        i_rst = 1'b1; i_in_valid = 1'b0; i_sub = '0; i_input0 = '0; i_input1 = '0;
        i_out_ready = 1'b1; i_ovf_clr = 1'b0;
        #12;
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_output",    o_output,          32'd0);
        chk("rst_ovf",       32'(o_ovf),        32'd0);
        chk("rst_ovf_cnt",   32'(o_ovf_cnt),    32'd0);
        tick();
        i_rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(o_in_ready), 32'd1);

        run1(2'b10, {16'h0080, 16'h0100}, {16'h0100, 16'h8080});
        chk("t1_valid",  32'(o_out_valid), 32'd1);
        chk("t1_output", o_output,          {16'h8080, 16'h0080});
        chk("t1_ovf",    32'(o_ovf),        32'd0);

        run1(2'b00, {16'hF000, 16'h7000}, {16'hA000, 16'h2000});
        chk("t2_sat_output",  o_output,       {16'hFFFF, 16'h7FFF});
        chk("t2_sat_ovf",     32'(o_ovf),     32'd3);
        chk("t2_wrap_output", o_output_w,     {16'h9000, 16'h1000});
        chk("t2_wrap_ovf",    32'(o_ovf_w),   32'd3);

        run1(2'b00, {16'h0005, 16'h8000}, {16'h8005, 16'h0000});
        chk("t3_zero_sum", o_output, 32'd0);
        run1(2'b01, {16'hC000, 16'h0005}, {16'hC000, 16'h0005});
        chk("t3_sat_output",  o_output,     {16'hFFFF, 16'h0000});
        chk("t3_sat_ovf",     32'(o_ovf),   32'd2);
        chk("t3_wrap_zero",   o_output_w,   32'd0);
        chk("t3_wrap_ovf",    32'(o_ovf_w), 32'd2);
        tick();
        chk("t3_drained", 32'(o_out_valid), 32'd0);

        sent = 0; recv = 0;
        i_input1 = {16'h0010, 16'h0010}; i_sub = 2'b10;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            i_out_ready = !(cyc >= 3 && cyc <= 5);
            i_in_valid  = (sent < 6);
            i_input0    = {16'(sent + 1), 16'(sent + 1)};
            #1;
            if (cyc == 2) chk("t4_full_shift_ready", 32'(o_in_ready), 32'd1);
            if (cyc >= 3 && cyc <= 5) begin
                chk("t4_stall_ready", 32'(o_in_ready),  32'd0);
                chk("t4_stall_valid", 32'(o_out_valid), 32'd1);
                chk("t4_stall_hold",  o_output,          exp4(1));
            end
            if (o_out_valid && i_out_ready) begin
                chk("t4_order", o_output, exp4(recv));
                recv++;
            end
            if (i_in_valid && o_in_ready) sent++;
            tick();
        end
        i_in_valid = 1'b0; i_out_ready = 1'b1;
        chk("t4_recv_count", 32'(recv), 32'd6);
        tick();
        chk("t4_no_dup", 32'(o_out_valid), 32'd0);

        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("t5_clear", 32'(o_ovf_cnt), 32'd0);
        run1(2'b10, {16'h0080, 16'h0100}, {16'h0100, 16'h8080});
        tick();
        chk("t5_no_ovf_no_count", 32'(o_ovf_cnt), 32'd0);
        i_sub = 2'b00; i_input0 = {16'h0000, 16'h7000}; i_input1 = {16'h0000, 16'h2000};
        i_in_valid = 1'b1;
        repeat (10) tick();
        i_in_valid = 1'b0;
        repeat (3) tick();
        chk("t5_count10", 32'(o_ovf_cnt), 32'd10);
        i_in_valid = 1'b1;
        repeat (300) tick();
        i_in_valid = 1'b0;
        repeat (3) tick();
        chk("t5_sat_ff",      32'(o_ovf_cnt),   32'hFF);
        chk("t5_wrap_sat_ff", 32'(o_ovf_cnt_w), 32'hFF);
        i_in_valid = 1'b1;
        tick();
        tick();
        i_ovf_clr = 1'b1;
        #1;
        chk("t5_clr_fire_pre", 32'(o_out_valid && o_ovf != 2'b00), 32'd1);
        tick();
        i_ovf_clr = 1'b0; i_in_valid = 1'b0;
        chk("t5_clr_wins", 32'(o_ovf_cnt), 32'd0);
        repeat (3) tick();
        chk("t5_after_clr", 32'(o_ovf_cnt), 32'd2);

        i_out_ready = 1'b0; i_in_valid = 1'b1;
        i_sub = 2'b00; i_input0 = {16'h0001, 16'h0001}; i_input1 = {16'h0001, 16'h0001};
        tick();
        tick();
        i_in_valid = 1'b0;
        #1;
        chk("t6_pre_valid", 32'(o_out_valid), 32'd1);
        chk("t6_pre_full",  32'(o_in_ready),  32'd0);
        #2;
        i_rst = 1'b1;
        #1;
        chk("t6_async_valid",  32'(o_out_valid), 32'd0);
        chk("t6_async_cnt",    32'(o_ovf_cnt),   32'd0);
        chk("t6_async_output", o_output,         32'd0);
        tick();
        i_rst = 1'b0; i_out_ready = 1'b1;
        #1;
        chk("t6_ready_after", 32'(o_in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_stale", 32'(o_out_valid), 32'd0);
        end
        run1(2'b01, {16'h0003, 16'h0002}, {16'h0001, 16'h0005});
        chk("t6_new_valid",  32'(o_out_valid), 32'd1);
        chk("t6_new_output", o_output,          {16'h0004, 16'h8003});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
